// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV32 load/store against an internal
// word array, with sizing, extension, error checks and fixed wait states.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 2);
   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [2:0]         f3_q, f3_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [1:0]         lane_q, lane_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               err_q, err_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               rerr_q, rerr_d;

   logic [31:0]        mem_q [DEPTH_WORDS];
   logic               err_c;
   logic               access_c;
   logic               wr_en_c;
   logic [31:0]        rd_word_c;
   logic [31:0]        sh_c;
   logic [31:0]        ld_c;
   logic [31:0]        wr_data_c;

   // Request legality, evaluated at accept time
   always_comb begin
      err_c = 1'b0;
      case (req_funct3)
         3'b000, 3'b100: err_c = 1'b0;
         3'b001, 3'b101: err_c = req_addr[0];
         3'b010:         err_c = |req_addr[1:0];
         default:        err_c = 1'b1;
      endcase
      if (req_we && req_funct3[2]) err_c = 1'b1;
      if ({2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS)) err_c = 1'b1;
   end

   // Load lane select/extension and store lane merge
   always_comb begin
      rd_word_c = mem_q[idx_q];
      sh_c      = rd_word_c >> {lane_q, 3'b000};
      case (f3_q)
         3'b000:  ld_c = {{24{sh_c[7]}}, sh_c[7:0]};
         3'b001:  ld_c = {{16{sh_c[15]}}, sh_c[15:0]};
         3'b010:  ld_c = rd_word_c;
         3'b100:  ld_c = {24'd0, sh_c[7:0]};
         3'b101:  ld_c = {16'd0, sh_c[15:0]};
         default: ld_c = 32'd0;
      endcase
      wr_data_c = rd_word_c;
      case (f3_q[1:0])
         2'b00:   wr_data_c[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
         2'b01:   wr_data_c[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: wr_data_c = wdata_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      f3_d     = f3_q;
      idx_d    = idx_q;
      lane_d   = lane_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      rerr_d   = rerr_q;
      access_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               idx_d   = req_addr[IDX_W+1:2];
               lane_d  = req_addr[1:0];
               wdata_d = req_wdata;
               err_d   = err_c;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Counter reaching zero marks the access edge
            if (cnt_q == '0) begin
               access_c = 1'b1;
               rdata_d  = (err_q || we_q) ? 32'd0 : ld_c;
               rerr_d   = err_q;
               state_d  = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign wr_en_c = access_c && we_q && !err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         idx_q   <= '0;
         lane_q  <= 2'd0;
         wdata_q <= 32'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
      end
   end

   // Array contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en_c) mem_q[idx_q] <= wr_data_c;
   end

   assign req_ready = (state_q == ST_IDLE) && reset;
   assign busy      = (state_q != ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = rerr_q;

endmodule
